// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - byte-stream program loader for instruction memory
// Receives a 16-bit word count and little-endian words, writing each word while holding the CPU in reset.
module imem_loader #(
  parameter int          MAX_WORDS = 64,
  parameter logic [31:0] ADDR_BASE = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  input  logic        load,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        cpu_reset,
  output logic        done,
  output logic        error
);

  typedef enum logic [2:0] {
    CNT0  = 3'd0,
    CNT1  = 3'd1,
    DATA  = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4,
    ERROR = 3'd5
  } state_t;

  localparam logic [31:0] MAX_W = 32'(MAX_WORDS);

  state_t      state_q, state_d;
  logic [15:0] n_q, n_d;
  logic [15:0] idx_q, idx_d;
  logic [1:0]  k_q, k_d;
  logic [31:0] word_q, word_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        accept;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= CNT0;
      n_q     <= '0;
      idx_q   <= '0;
      k_q     <= '0;
      word_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      idx_q   <= idx_d;
      k_q     <= k_d;
      word_q  <= word_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    idx_d   = idx_q;
    k_d     = k_q;
    word_d  = word_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    accept  = rx_valid && rx_ready;

    case (state_q)
      CNT0: begin
        if (accept) begin
          n_d     = {8'h00, rx_data};
          state_d = CNT1;
        end
      end
      CNT1: begin
        if (accept) begin
          n_d = {rx_data, n_q[7:0]};
          if ({16'h0000, n_d} > MAX_W) state_d = ERROR;
          else if (n_d == 16'h0000)    state_d = DONE;
          else                         state_d = DATA;
        end
      end
      DATA: begin
        if (accept) begin
          word_d[{k_q, 3'b000} +: 8] = rx_data;
          k_d = k_q + 2'd1;
          // Output registers only change on entry to WRITE so they hold between writes.
          if (k_q == 2'd3) begin
            wdata_d = word_d;
            addr_d  = ADDR_BASE + {14'b0, idx_q, 2'b00};
            state_d = WRITE;
          end
        end
      end
      WRITE: begin
        idx_d   = idx_q + 16'd1;
        state_d = (idx_d == n_q) ? DONE : DATA;
      end
      DONE, ERROR: begin
        if (load) begin
          state_d = CNT0;
          n_d     = '0;
          idx_d   = '0;
          k_d     = '0;
        end
      end
      default: state_d = CNT0;
    endcase
  end

  assign rx_ready   = (state_q == CNT0) || (state_q == CNT1) || (state_q == DATA);
  assign imem_we    = (state_q == WRITE);
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign cpu_reset  = (state_q != DONE);
  assign done       = (state_q == DONE);
  assign error      = (state_q == ERROR);

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - randomized self-checking bench for imem_loader
// Expected writes come from the word list itself: word i lands at ADDR_BASE + 4*i.
module tb_imem_loader;

  localparam int          MAX_WORDS = 64;
  localparam logic [31:0] ADDR_BASE = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        load;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_reset;
  logic        done;
  logic        error;

  imem_loader #(.MAX_WORDS(MAX_WORDS), .ADDR_BASE(ADDR_BASE)) dut (
    .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(rx_ready), .load(load), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .cpu_reset(cpu_reset), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  logic [31:0] words[$];
  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_data_q[$];
  logic [31:0] last_addr = '0;
  logic [31:0] last_data = '0;
  bit          load_noise = 1'b0;

  // Every write must match the head of the expected queue; outside writes the outputs hold.
  always @(negedge clk) begin
    if (reset) begin
      last_addr = '0;
      last_data = '0;
    end else begin
      check("cpu_reset_vs_done", cpu_reset, !done);
      check("done_and_error", done & error, 0);
      if (imem_we) begin
        if (exp_addr_q.size() == 0) begin
          check("unexpected_write", 1, 0);
        end else begin
          last_addr = exp_addr_q.pop_front();
          last_data = exp_data_q.pop_front();
          check("write_addr", imem_addr, last_addr);
          check("write_data", imem_wdata, last_data);
          check("write_cpu_reset", cpu_reset, 1);
        end
      end else begin
        check("addr_hold", imem_addr, last_addr);
        check("wdata_hold", imem_wdata, last_data);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    int waited;
    waited = 0;
    if (gap > 0) begin
      rx_valid = 1'b0;
      repeat (gap) begin
        load = load_noise ? 1'($urandom) : 1'b0;
        @(negedge clk);
      end
    end
    rx_valid = 1'b1;
    rx_data  = b;
    while (!rx_ready) begin
      load = load_noise ? 1'($urandom) : 1'b0;
      @(negedge clk);
      waited++;
      if (waited > 20) begin
        check("rx_ready_timeout", 0, 1);
        return;
      end
    end
    load = load_noise ? 1'($urandom) : 1'b0;
    @(negedge clk);
  endtask

  task automatic run_load(input int n, input int gap_max);
    logic [31:0] w;
    logic [15:0] n16;
    bit          ovf;
    n16 = 16'(n);
    ovf = (n > MAX_WORDS);
    exp_addr_q.delete();
    exp_data_q.delete();
    if (!ovf)
      for (int i = 0; i < n; i++) begin
        exp_addr_q.push_back(ADDR_BASE + 32'(4 * i));
        exp_data_q.push_back(words[i]);
      end
    send_byte(n16[7:0], $urandom_range(0, gap_max));
    send_byte(n16[15:8], $urandom_range(0, gap_max));
    if (!ovf)
      for (int i = 0; i < n; i++) begin
        w = words[i];
        for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], $urandom_range(0, gap_max));
      end
    load = 1'b0;
    // Junk stays offered afterwards; it must not be consumed in WRITE, DONE or ERROR.
    rx_data = 8'($urandom);
    if (!ovf && n > 0) @(negedge clk);
    check("end_done", done, !ovf);
    check("end_error", error, ovf);
    check("end_rx_ready", rx_ready, 0);
    check("end_cpu_reset", cpu_reset, ovf);
    repeat (3) @(negedge clk);
    check("hold_done", done, !ovf);
    check("hold_error", error, ovf);
    check("writes_left", exp_addr_q.size(), 0);
    rx_valid = 1'b0;
  endtask

  task automatic do_load();
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    check("load_rx_ready", rx_ready, 1);
    check("load_done", done, 0);
    check("load_error", error, 0);
    check("load_cpu_reset", cpu_reset, 1);
  endtask

  task automatic set_random_words(input int n);
    words.delete();
    for (int i = 0; i < n; i++) words.push_back($urandom);
  endtask

  initial begin
    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    load     = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_we", imem_we, 0);
    check("rst_addr", imem_addr, 0);
    check("rst_wdata", imem_wdata, 0);
    check("rst_cpu_reset", cpu_reset, 1);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_rx_ready", rx_ready, 1);
    reset = 1'b0;
    @(negedge clk);

    words = '{32'h0000_0513, 32'h0010_0593};
    run_load(2, 0);

    do_load();
    words.delete();
    run_load(0, 0);

    do_load();
    run_load(65, 0);
    do_load();
    run_load(256, 1);
    do_load();

    // Reset in the middle of a word: partial data is discarded, load during reset is ignored.
    exp_addr_q.delete();
    exp_data_q.delete();
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    rx_valid = 1'b0;
    reset    = 1'b1;
    load     = 1'b1;
    #1;
    check("midrst_we", imem_we, 0);
    check("midrst_addr", imem_addr, 0);
    check("midrst_wdata", imem_wdata, 0);
    check("midrst_rx_ready", rx_ready, 1);
    check("midrst_cpu_reset", cpu_reset, 1);
    @(negedge clk);
    reset = 1'b0;
    load  = 1'b0;
    set_random_words(3);
    run_load(3, 2);

    do_load();
    words = '{32'hDEAD_BEEF};
    run_load(1, 0);

    do_load();
    set_random_words(MAX_WORDS);
    run_load(MAX_WORDS, 0);

    do_load();
    set_random_words(5);
    run_load(5, 0);
    do_load();
    run_load(5, 6);

    for (int it = 0; it < 25; it++) begin
      int n;
      do_load();
      n = ($urandom_range(0, 7) == 0) ? $urandom_range(60, 70) : $urandom_range(0, 6);
      set_random_words(n);
      load_noise = 1'($urandom);
      run_load(n, $urandom_range(0, 3));
      load_noise = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 The block SHALL have parameter MAX_WORDS, default 64, giving the instruction-memory capacity in 32-bit words.
REQ-002 The block SHALL have parameter ADDR_BASE, default 32'h0000_0000, giving the byte address of the first word written.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 The block SHALL have port rx_valid, input, 1, upstream byte available.
REQ-006 The block SHALL have port rx_data, input, 8, upstream byte.
REQ-007 The block SHALL have port rx_ready, output, 1, loader can accept a byte.
REQ-008 The block SHALL have port load, input, 1, request to start a new program load.
REQ-009 The block SHALL have port imem_we, output, 1, instruction-memory write enable.
REQ-010 The block SHALL have port imem_addr, output, 32, word-aligned byte address of the write.
REQ-011 The block SHALL have port imem_wdata, output, 32, instruction word to write.
REQ-012 The block SHALL have port cpu_reset, output, 1, holds the processor in reset while loading.
REQ-013 The block SHALL have port done, output, 1, program fully loaded.
REQ-014 The block SHALL have port error, output, 1, word count exceeds MAX_WORDS.

Function
REQ-015 The block SHALL be a Moore FSM: all outputs are driven from registers or decoded from the state register only, never from rx_valid, rx_data or load.
REQ-016 The states SHALL be CNT0, CNT1, DATA, WRITE, DONE and ERROR.
REQ-017 A byte SHALL be accepted on a rising edge only when rx_valid=1 and rx_ready=1.
REQ-018 rx_ready SHALL be 1 in CNT0, CNT1 and DATA, and 0 in WRITE, DONE and ERROR.
REQ-019 The stream format SHALL be a 16-bit word count N (low byte first), followed by 4N instruction bytes, each word sent little-endian (first byte goes to bits [7:0]).
REQ-020 In CNT0, an accepted byte SHALL be stored as N[7:0], and the FSM SHALL go to CNT1.
REQ-021 In CNT1, an accepted byte SHALL be stored as N[15:8], and the FSM SHALL then go:
- to ERROR if N > MAX_WORDS;
- to DONE if N = 0;
- otherwise to DATA.
REQ-022 In DATA, each accepted byte SHALL be placed at bits [8k+7:8k] of imem_wdata, where k is a 2-bit byte counter; after the byte with k=3 the FSM SHALL go to WRITE and k SHALL wrap to 0.
REQ-023 WRITE SHALL last exactly one cycle, with the following outputs in that cycle:
- imem_we=1;
- imem_addr = ADDR_BASE + 4*idx, computed modulo 2^32;
- imem_wdata = the assembled word.
REQ-024 On leaving WRITE, idx SHALL increment; the FSM SHALL go to DONE if idx+1 = N, else back to DATA.
REQ-025 imem_we SHALL be 0 in every state other than WRITE; imem_addr and imem_wdata SHALL hold their last values outside WRITE.
REQ-026 cpu_reset SHALL be 1 in every state except DONE.
REQ-027 done SHALL be 1 only in DONE, and error SHALL be 1 only in ERROR.
REQ-028 In DONE or ERROR, load=1 SHALL send the FSM to CNT0 and clear N, idx and k; load SHALL be ignored in all other states.
REQ-029 rx_valid while rx_ready=0 SHALL have no effect, and no byte SHALL be consumed.
REQ-030 Pauses of any length in rx_valid between bytes SHALL be tolerated with no timeout.

Reset
REQ-031 While reset=1, the FSM SHALL be forced asynchronously to CNT0 with the following values:
- N=0, idx=0, k=0;
- imem_we=0, imem_addr=0, imem_wdata=0;
- cpu_reset=1, done=0, error=0, rx_ready=1.
REQ-032 Reset asserted in the middle of a load SHALL discard any partial word and count, with no further write issued.
REQ-033 When reset and load are asserted together, reset SHALL take priority.

Verification
REQ-034 Load two words: stream 02 00 13 05 00 00 93 05 10 00 -> two single-cycle writes (0x00000000, 0x00000513) then (0x00000004, 0x00100593); done=1 and cpu_reset=0 in the cycle after the second write.
REQ-035 Empty program: stream 00 00 -> DONE with no imem_we pulse; done=1 and cpu_reset=0.
REQ-036 Overflow: with MAX_WORDS=64, stream 41 00 -> error=1, cpu_reset=1, rx_ready=0; a later load pulse -> CNT0 with error=0.
REQ-037 Back-pressure and gaps: rx_valid held high during WRITE -> no byte lost or duplicated; random idle gaps between bytes -> identical write sequence to the gap-free case.
REQ-038 Reset mid-word: reset after 2 of 4 data bytes -> state CNT0, no write; a fresh stream then loads correctly starting at ADDR_BASE.
REQ-039 Reload: in DONE, pulse load, then stream 01 00 EF BE AD DE -> cpu_reset=1 during the load, one write of (0x00000000, 0xDEADBEEF), then done=1.
